// File: rtl/auto_whacker.sv
// auto_whacker -- synthetic whack-a-mole player.
//
// Watches the live mole mask. Once a mole lights, it waits a reaction delay
// counted in 1 ms ticks, then inverts the matching synthetic switch. After
// that it holds the new switch level, and then waits for the mole to go dark.
// It also counts the whacks it issues and the targets it abandons, so that
// score_core can be cross-checked against these counts.
//
// Ports:
//   CLOCK_50     in   1        system clock (50 MHz)
//   rst_n        in   1        asynchronous active-low reset
//   tick_1ms     in   1        one-cycle 1 kHz clock enable
//   enable       in   1        auto-play permitted (level)
//   active_mask  in   N_MOLES  moles currently lit
//   rnd          in   8        free-running LFSR, sampled at target latch
//   sw_out       out  N_MOLES  synthetic switch levels
//   busy         out  1        high whenever not IDLE
//   target_idx   out  5        current or last target index
//   whack_count  out  16       toggles issued, saturating
//   miss_count   out  8        targets abandoned, saturating
module auto_whacker #(
    parameter int N_MOLES          = 18,
    parameter int REACT_MS         = 150,
    parameter int JITTER_EN        = 1,
    parameter int HOLD_MS          = 12,
    parameter int CLEAR_TIMEOUT_MS = 2000,
    parameter int MISS_EVERY       = 0
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    input  logic               tick_1ms,
    input  logic               enable,
    input  logic [N_MOLES-1:0] active_mask,
    input  logic [7:0]         rnd,
    output logic [N_MOLES-1:0] sw_out,
    output logic               busy,
    output logic [4:0]         target_idx,
    output logic [15:0]        whack_count,
    output logic [7:0]         miss_count
);

    // The ms counter has to hold the longest delay that can ever be loaded.
    localparam int REACT_MAX = REACT_MS + 120;
    localparam int MAX_A     = (CLEAR_TIMEOUT_MS > REACT_MAX) ? CLEAR_TIMEOUT_MS : REACT_MAX;
    localparam int MAX_MS    = (HOLD_MS > MAX_A) ? HOLD_MS : MAX_A;
    localparam int CNT_W     = $clog2(MAX_MS + 1);
    localparam int SKIP_W    = (MISS_EVERY > 0) ? $clog2(MISS_EVERY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REACT,
        TOGGLE,
        HOLD,
        WAIT_CLEAR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SKIP_W-1:0]  skip_q;
    logic               planned_q;
    logic [N_MOLES-1:0] sw_q;
    logic               busy_q;
    logic [4:0]         target_q;
    logic [15:0]        whack_q;
    logic [7:0]         miss_q;

    logic [11:0]        react_sum;
    logic [SKIP_W-1:0]  skip_d;
    logic               planned_d;
    logic [N_MOLES-1:0] tgt_bit;
    logic               mole_lit;
    logic               unused_rnd;

    function automatic logic [4:0] lowest_set(input logic [N_MOLES-1:0] m);
        logic [4:0] idx;
        idx = '0;
        for (int i = N_MOLES - 1; i >= 0; i--) begin
            if (m[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reaction delay is formed in 12 bits: base plus optional rnd[3:0]*8 jitter.
    assign react_sum = 12'(REACT_MS) + ((JITTER_EN != 0) ? {5'd0, rnd[3:0], 3'd0} : 12'd0);
    assign unused_rnd = ^rnd[7:4];

    // Skip counter advances on each latch; reaching MISS_EVERY marks a planned miss.
    assign planned_d = (MISS_EVERY != 0) && ((skip_q + 1'b1) == SKIP_W'(MISS_EVERY));
    assign skip_d    = planned_d ? '0 : skip_q + 1'b1;

    assign tgt_bit  = N_MOLES'(1) << target_q;
    assign mole_lit = |(active_mask & tgt_bit);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            skip_q    <= '0;
            planned_q <= 1'b0;
            sw_q      <= '0;
            busy_q    <= 1'b0;
            target_q  <= '0;
            whack_q   <= '0;
            miss_q    <= '0;
        end else if (!enable) begin
            // Abort without touching counters; switch levels are left as they are.
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|active_mask) begin
                        target_q  <= lowest_set(active_mask);
                        cnt_q     <= CNT_W'(react_sum);
                        skip_q    <= skip_d;
                        planned_q <= planned_d;
                        state_q   <= REACT;
                        busy_q    <= 1'b1;
                    end
                end
                REACT: begin
                    // A mole drop takes priority over an expiry in the same cycle.
                    if (!mole_lit) begin
                        miss_q  <= sat_inc8(miss_q);
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_1ms) begin
                        if (cnt_q == '0) begin
                            if (planned_q) begin
                                cnt_q   <= CNT_W'(CLEAR_TIMEOUT_MS);
                                state_q <= WAIT_CLEAR;
                            end else begin
                                state_q <= TOGGLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                TOGGLE: begin
                    sw_q    <= sw_q ^ tgt_bit;
                    whack_q <= sat_inc16(whack_q);
                    cnt_q   <= CNT_W'(HOLD_MS);
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (tick_1ms) begin
                        if (cnt_q == '0) begin
                            cnt_q   <= CNT_W'(CLEAR_TIMEOUT_MS);
                            state_q <= WAIT_CLEAR;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                WAIT_CLEAR: begin
                    // Waiting for the mole to go dark keeps a still-lit mole from a second whack.
                    if (!mole_lit || (tick_1ms && (cnt_q == '0))) begin
                        if (planned_q) miss_q <= sat_inc8(miss_q);
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_1ms) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sw_out      = sw_q;
    assign busy        = busy_q;
    assign target_idx  = target_q;
    assign whack_count = whack_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_auto_whacker.sv
module tb_auto_whacker;

    localparam int N     = 18;
    localparam int REACT = 10;
    localparam int JIT   = 1;
    localparam int HOLD  = 3;
    localparam int CLR   = 40;
    localparam int MISS  = 3;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic          enable;
    logic [N-1:0]  mask;
    logic [7:0]    rnd;
    logic [N-1:0]  sw_out;
    logic          busy;
    logic [4:0]    target_idx;
    logic [15:0]   whack_count;
    logic [7:0]    miss_count;

    auto_whacker #(
        .N_MOLES         (N),
        .REACT_MS        (REACT),
        .JITTER_EN       (JIT),
        .HOLD_MS         (HOLD),
        .CLEAR_TIMEOUT_MS(CLR),
        .MISS_EVERY      (MISS)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .tick_1ms   (tick),
        .enable     (enable),
        .active_mask(mask),
        .rnd        (rnd),
        .sw_out     (sw_out),
        .busy       (busy),
        .target_idx (target_idx),
        .whack_count(whack_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: expected switch levels, counts and the number of latches.
    int           n_vec;
    int           n_err;
    logic [N-1:0] exp_sw;
    int           exp_whack;
    int           exp_miss;
    int           latch_n;
    logic [N-1:0] mask_cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // n tick cycles, with occasional tick-free cycles mixed in.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0);
            step(1'b1);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        int idx;
        idx = -1;
        for (int i = N - 1; i >= 0; i--) if (m[i]) idx = i;
        return idx;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_sw"},    32'(sw_out),      32'(exp_sw));
        check({tag, "_whack"}, 32'(whack_count), 32'(exp_whack));
        check({tag, "_miss"},  32'(miss_count),  32'(exp_miss));
    endtask

    function automatic void add_miss();
        if (exp_miss < 255) exp_miss++;
    endfunction

    // One target from latch to return to IDLE.
    // mode 0: mole drops during reaction, 1: drop on the expiry tick,
    // 2: clears after the whack, 3: clear timeout, 4: enable dropped late,
    // 5: immediate drop right after latch.
    task automatic round(input int mode);
        int           tgt;
        int           r;
        int           d;
        bit           planned;
        logic [N-1:0] bitm;
        if (mask_cur == '0) begin
            mask_cur = N'(1) << $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0) mask_cur |= N'(1) << $urandom_range(0, N - 1);
        end
        tgt  = lowest(mask_cur);
        bitm = N'(1) << tgt;
        r    = int'($urandom_range(0, 255));
        check("idle_busy", 32'(busy), 32'd0);
        rnd  = 8'(r);
        mask = mask_cur;
        step(1'b0);
        latch_n++;
        planned = (latch_n % MISS) == 0;
        d = REACT + ((JIT != 0) ? (r % 16) * 8 : 0);
        check("latch_busy", 32'(busy), 32'd1);
        check("latch_tgt", 32'(target_idx), 32'(tgt));
        case (mode)
            0, 5: begin
                ticks((mode == 5) ? 0 : int'($urandom_range(0, d)));
                mask_cur &= ~bitm;
                mask = mask_cur;
                step(1'b0);
                add_miss();
                check("drop_busy", 32'(busy), 32'd0);
                check_state("drop");
            end
            1: begin
                ticks(d);
                mask_cur &= ~bitm;
                mask = mask_cur;
                step(1'b1);
                add_miss();
                check("tiedrop_busy", 32'(busy), 32'd0);
                check_state("tiedrop");
            end
            default: begin
                ticks(d + 1);
                if (!planned) begin
                    check("pre_toggle_sw", 32'(sw_out), 32'(exp_sw));
                    step(1'b0);
                    exp_sw ^= bitm;
                    exp_whack++;
                    check_state("toggle");
                    if (mode == 4) begin
                        ticks(int'($urandom_range(0, HOLD - 1)));
                        check("hold_busy", 32'(busy), 32'd1);
                        enable = 1'b0;
                        step(1'b0);
                        check("en_busy", 32'(busy), 32'd0);
                        check_state("en_hold");
                        mask_cur = '0;
                        mask = '0;
                        enable = 1'b1;
                        step(1'b0);
                        return;
                    end
                    ticks(HOLD + 1);
                end else begin
                    check("skip_sw", 32'(sw_out), 32'(exp_sw));
                end
                check("wait_busy", 32'(busy), 32'd1);
                if (mode == 4) begin
                    enable = 1'b0;
                    step(1'b0);
                    check("en_busy", 32'(busy), 32'd0);
                    check_state("en_wait");
                    mask_cur = '0;
                    mask = '0;
                    enable = 1'b1;
                    step(1'b0);
                end else if (mode == 3) begin
                    ticks(CLR + 1);
                    mask_cur = '0;
                    mask = '0;
                    if (planned) add_miss();
                    check("tmo_busy", 32'(busy), 32'd0);
                    check_state("tmo");
                end else begin
                    mask_cur &= ~bitm;
                    mask = mask_cur;
                    step(1'b0);
                    if (planned) add_miss();
                    check("clr_busy", 32'(busy), 32'd0);
                    check_state("clr");
                end
            end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0;
        exp_sw = '0; exp_whack = 0; exp_miss = 0; latch_n = 0;
        mask_cur = '0;
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; mask = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sw",    32'(sw_out),      32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_tgt",   32'(target_idx),  32'd0);
        check("rst_whack", 32'(whack_count), 32'd0);
        check("rst_miss",  32'(miss_count),  32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step(1'b0);

        // Two moles lit together: lowest first, then the other one.
        mask_cur = (N'(1) << 3) | (N'(1) << 9);
        round(2);
        round(2);
        check("pair_sw", 32'(sw_out), 32'h0000_0208);

        for (int k = 0; k < 60; k++) round(int'($urandom_range(0, 4)));

        // Drive the miss counter into saturation.
        mask_cur = '0;
        for (int k = 0; k < 262; k++) round(5);
        check("miss_sat", 32'(miss_count), 32'd255);

        // Asynchronous reset in the middle of a reaction delay.
        mask_cur = N'(1) << 6;
        rnd  = 8'h05;
        mask = mask_cur;
        step(1'b0);
        ticks(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_sw = '0; exp_whack = 0; exp_miss = 0; latch_n = 0;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tgt",  32'(target_idx), 32'd0);
        check_state("arst");
        mask_cur = '0;
        mask = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ticks(200);
        check("post_rst_busy", 32'(busy), 32'd0);
        check_state("post_rst");
        round(2);
        round(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/auto_whacker.md
Name: auto_whacker

Overview:
- Synthetic player for the whack-a-mole game; drives the far end of the LED/switch interface.
- Watches the live mole mask (LEDR drive), waits a human-like reaction time, then toggles the matching switch.
- Its output replaces SW at the debounce input for demo/attract mode and self-test.
- Keeps its own counts of whacks issued and moles missed, so score_core can be checked against it.

Parameters:
- N_MOLES, 18, width of mole mask and switch vector (1..32).
- REACT_MS, 150, base reaction delay in ms before toggling.
- JITTER_EN, 1, if 1, add rnd[3:0]*8 ms (0..120) to the reaction delay.
- HOLD_MS, 12, ms to hold a new switch level before watching for the mole to clear. Must exceed the switch debounce STABLE_TICKS.
- CLEAR_TIMEOUT_MS, 2000, maximum ms in WAIT_CLEAR before giving up.
- MISS_EVERY, 0, deliberately skip every Nth target; 0 = never skip.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick_1ms  in  1  one-cycle 1 kHz clock enable.
- enable  in  1  level; high = auto-play permitted (game_active & demo mode).
- active_mask  in  N_MOLES  moles currently lit.
- rnd  in  8  free-running LFSR value, sampled at target latch.
- sw_out  out  N_MOLES  synthetic switch levels.
- busy  out  1  high in any state other than IDLE.
- target_idx  out  5  index of the current or last target.
- whack_count  out  16  toggles issued; saturates at 16'hFFFF.
- miss_count  out  8  targets abandoned; saturates at 8'hFF.

Behaviour:
- Reset (async): all outputs 0; state IDLE; internal ms counter 0; skip counter 0.
- States: IDLE, REACT, TOGGLE, HOLD, WAIT_CLEAR.
- IDLE -> REACT when enable=1 and active_mask != 0. On that same edge:
  - Latch target_idx = lowest set bit of active_mask.
  - Load ms counter = REACT_MS + (JITTER_EN ? rnd[3:0]*8 : 0).
  - Advance skip counter.
- Skip rule: if MISS_EVERY != 0 and the skip counter reaches MISS_EVERY, the target is a planned miss.
  - Counter resets to 0.
  - REACT proceeds, but at expiry goes to WAIT_CLEAR without toggling.
  - miss_count increments when WAIT_CLEAR exits.
- REACT:
  - Counter decrements only on tick_1ms.
  - If active_mask[target_idx] falls to 0 before expiry: miss_count += 1, go to IDLE.
  - Expiry means the counter is 0 on a tick. Then go to TOGGLE, or to WAIT_CLEAR for a planned miss.
- TOGGLE: exactly one cycle.
  - sw_out[target_idx] inverts; the other bits are unchanged.
  - whack_count += 1.
  - Load ms counter = HOLD_MS; go to HOLD.
- HOLD: decrement on tick_1ms; at 0 go to WAIT_CLEAR with ms counter = CLEAR_TIMEOUT_MS.
- WAIT_CLEAR:
  - Exit to IDLE when active_mask[target_idx] == 0.
  - Also exit to IDLE on timeout; timeout does not count as a miss unless it was a planned miss.
  - Required so the same lit mole is never whacked twice.
- enable deasserted in any state: go to IDLE on the next clock.
  - No counter updates that cycle.
  - sw_out keeps its levels; switches never snap back.
- Simultaneous events:
  - In REACT, expiry and mole-drop on the same cycle: the drop wins (miss).
  - In IDLE, multiple moles lit: the lowest index wins; the others are handled on later passes.
- Latency from a mole lighting (enable=1, IDLE) to the sw_out edge: 1 cycle to latch, then the reaction delay in ticks, then 1 cycle.
- busy = (state != IDLE), registered.
- Counter widths are fixed; no wrap-around on either count.
- The reaction-delay sum is computed in 12 bits.
- The ms counter is wide enough for max(CLEAR_TIMEOUT_MS, REACT_MS+120).

Test Plan:
- Mole 5 lit, enable=1, JITTER_EN=0, REACT_MS=150 -> sw_out[5] toggles 0->1 on the cycle after the 151st tick_1ms after latch; whack_count=1; other bits stay 0.
- Moles 3 and 9 lit together -> target_idx=3 first; after mole 3 clears, target 9 is whacked; whack_count=2; sw_out=bits 3 and 9 set.
- Mole 7 lit, cleared after 50 ms (REACT_MS=150) -> no toggle; miss_count=1; return to IDLE.
- MISS_EVERY=3, six sequential single moles -> exactly targets 3 and 6 untoggled; whack_count=4; miss_count=2.
- enable dropped mid-HOLD on mole 2 -> IDLE next clock; sw_out[2] stays 1; a second whack of mole 2 later toggles it 1->0.
- rst_n pulsed low mid-REACT -> all outputs 0 immediately (async); after release, no toggle until a new mole is latched.
